rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_pkg.sv | 36 +++
 rtl/rf_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_write_arbiter_pkg
// Purpose : Shared widths, defaults and types for the register-file write
//           arbiter: forwarding-bus width, {we, addr, data} write-bus layout,
//           starvation-limit default and the two-state buffer control.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

  localparam int c_REG_ADDR_W          = 5;
  localparam int c_DATA_W              = 32;
  localparam int c_FWD_BUS_W           = c_REG_ADDR_W + c_DATA_W;      // 37
  localparam int c_RF_WBUS_W           = 1 + c_REG_ADDR_W + c_DATA_W;  // 38
  localparam int c_STARVE_LIMIT_DEFAULT = 3;

  // IDLE: buffer empty, PEND: one LU write buffered.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                    we;
    logic [c_REG_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0]     data;
  } rf_wbus_t;

  // Forwarding bus carries {dest, data} of the committed write, zero otherwise.
  function automatic logic [c_FWD_BUS_W-1:0] fwd_pack(input rf_wbus_t w);
    return w.we ? {w.addr, w.data} : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rf_write_arbiter
// Purpose : Arbitrates the single register-file write port between the WB
//           stage and a long-latency unit (mul/div). LU results are captured
//           in a one-entry buffer and written no earlier than the cycle after
//           acceptance. WB normally wins; a buffered LU write is forced after
//           STARVE_LIMIT consecutive losses, or immediately when WB targets
//           the same register (the older LU write must land first).
// Ports   : clk, reset          - clock, synchronous active-high reset
//           ws_wr_valid/dest/data, ws_stall  - WB write request / hold
//           lu_valid/dest/data, lu_ready     - LU write-back handshake
//           rf_we/waddr/wdata                - register-file write port
//           fwd_bus                          - {dest,data} of this cycle's write
//           lu_pend, lu_pend_dest            - buffered LU write scoreboard hint
// Revision: 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  // WB stage
  input  logic                    ws_wr_valid,
  input  logic [c_REG_ADDR_W-1:0] ws_wr_dest,
  input  logic [c_DATA_W-1:0]     ws_wr_data,
  output logic                    ws_stall,
  // long-latency unit
  input  logic                    lu_valid,
  input  logic [c_REG_ADDR_W-1:0] lu_dest,
  input  logic [c_DATA_W-1:0]     lu_data,
  output logic                    lu_ready,
  // register file
  output logic                    rf_we,
  output logic [c_REG_ADDR_W-1:0] rf_waddr,
  output logic [c_DATA_W-1:0]     rf_wdata,
  // forwarding / hazard information
  output logic [c_FWD_BUS_W-1:0]  fwd_bus,
  output logic                    lu_pend,
  output logic [c_REG_ADDR_W-1:0] lu_pend_dest
);

  // Counter must be able to hold STARVE_LIMIT itself; keep at least one bit.
  localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_LIMIT);

  arb_state_e              state_q, state_d;
  logic [c_REG_ADDR_W-1:0] buf_dest_q, buf_dest_d;
  logic [c_DATA_W-1:0]     buf_data_q, buf_data_d;
  logic [c_CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

  logic     w_buf_valid;
  logic     w_ws_req;
  logic     w_lu_grant;
  logic     w_wb_grant;
  logic     w_lu_accept;
  rf_wbus_t w_wbus;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_dest_q   <= '0;
      buf_data_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      buf_dest_q   <= buf_dest_d;
      buf_data_q   <= buf_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Grant, write port and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_buf_valid = (state_q == ST_PEND);

    // Writes to r0 are architecturally void; they never compete for the port.
    w_ws_req = ws_wr_valid && (ws_wr_dest != '0);

    // No grants while reset is held: a buffered write being discarded by reset
    // must not reach the register file in the reset cycle either.
    w_lu_grant = !reset && w_buf_valid &&
                 (!w_ws_req || (starve_cnt_q == c_CNT_MAX) ||
                  (ws_wr_dest == buf_dest_q));
    w_wb_grant = !reset && w_ws_req && !w_lu_grant;

    // lu_ready depends only on buffer occupancy, so a draining buffer cannot
    // be refilled in the same cycle.
    w_lu_accept = lu_valid && !w_buf_valid;

    w_wbus = '0;
    if (w_lu_grant) begin
      w_wbus.we   = 1'b1;
      w_wbus.addr = buf_dest_q;
      w_wbus.data = buf_data_q;
    end else if (w_wb_grant) begin
      w_wbus.we   = 1'b1;
      w_wbus.addr = ws_wr_dest;
      w_wbus.data = ws_wr_data;
    end

    state_d      = state_q;
    buf_dest_d   = buf_dest_q;
    buf_data_d   = buf_data_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // An accepted write to r0 is simply dropped.
        if (w_lu_accept && (lu_dest != '0)) begin
          state_d      = ST_PEND;
          buf_dest_d   = lu_dest;
          buf_data_d   = lu_data;
          starve_cnt_d = '0;
        end
      end
      ST_PEND: begin
        if (w_lu_grant) begin
          state_d      = ST_IDLE;
          buf_dest_d   = '0;
          buf_data_d   = '0;
          starve_cnt_d = '0;
        end else if (w_wb_grant && (starve_cnt_q != c_CNT_MAX)) begin
          starve_cnt_d = starve_cnt_q + c_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ws_stall     = w_lu_grant && w_ws_req;
  assign lu_ready     = !w_buf_valid;
  assign rf_we        = w_wbus.we;
  assign rf_waddr     = w_wbus.addr;
  assign rf_wdata     = w_wbus.data;
  assign fwd_bus      = fwd_pack(w_wbus);
  assign lu_pend      = w_buf_valid;
  assign lu_pend_dest = w_buf_valid ? buf_dest_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_write_arbiter
// Purpose : Self-checking bench for rf_write_arbiter. Directed scenarios for
//           the key arbitration cases, then randomized traffic compared every
//           cycle against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_wr_valid;
  logic [4:0]  ws_wr_dest;
  logic [31:0] ws_wr_data;
  logic        ws_stall;
  logic        lu_valid;
  logic [4:0]  lu_dest;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [36:0] fwd_bus;
  logic        lu_pend;
  logic [4:0]  lu_pend_dest;

  always #5 clk = ~clk;

  rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .ws_wr_valid  (ws_wr_valid),
    .ws_wr_dest   (ws_wr_dest),
    .ws_wr_data   (ws_wr_data),
    .ws_stall     (ws_stall),
    .lu_valid     (lu_valid),
    .lu_dest      (lu_dest),
    .lu_data      (lu_data),
    .lu_ready     (lu_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fwd_bus      (fwd_bus),
    .lu_pend      (lu_pend),
    .lu_pend_dest (lu_pend_dest)
  );

  // Reference model: pending LU writes as a queue, starvation as an int.
  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  wr_t         pend_q[$];
  int          starve;
  int          n_vec;
  int          n_err;
  logic [31:0] rf_obs [32];
  logic        exp_stall;

  // Last observed DUT outputs of the most recent step.
  logic        obs_we, obs_stall, obs_ready, obs_pend;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, clock,
  // then advance the model.
  task automatic step(input logic r, input logic wv, input logic [4:0] wd,
                      input logic [31:0] wdat, input logic lv,
                      input logic [4:0] ld, input logic [31:0] ldat);
    logic        counted, lu_win, e_we, e_stall, e_ready;
    logic [4:0]  e_addr, e_pdest;
    logic [31:0] e_data;
    reset       = r;
    ws_wr_valid = wv;
    ws_wr_dest  = wd;
    ws_wr_data  = wdat;
    lu_valid    = lv;
    lu_dest     = ld;
    lu_data     = ldat;
    #2;
    counted = wv && (wd != 5'd0);
    e_ready = (pend_q.size() == 0);
    e_pdest = e_ready ? 5'd0 : pend_q[0].dest;
    lu_win  = !r && !e_ready &&
              (!counted || starve >= LIMIT || wd == pend_q[0].dest);
    e_we = 1'b0; e_addr = '0; e_data = '0; e_stall = 1'b0;
    if (lu_win) begin
      e_we = 1'b1; e_addr = pend_q[0].dest; e_data = pend_q[0].data; e_stall = counted;
    end else if (!r && counted) begin
      e_we = 1'b1; e_addr = wd; e_data = wdat;
    end
    check("rf_we",        64'(rf_we),        64'(e_we));
    check("rf_waddr",     64'(rf_waddr),     64'(e_addr));
    check("rf_wdata",     64'(rf_wdata),     64'(e_data));
    check("fwd_bus",      64'(fwd_bus),      64'({e_addr, e_data}));
    check("ws_stall",     64'(ws_stall),     64'(e_stall));
    check("lu_ready",     64'(lu_ready),     64'(e_ready));
    check("lu_pend",      64'(lu_pend),      64'(!e_ready));
    check("lu_pend_dest", 64'(lu_pend_dest), 64'(e_pdest));
    obs_we = rf_we; obs_addr = rf_waddr; obs_data = rf_wdata;
    obs_stall = ws_stall; obs_ready = lu_ready; obs_pend = lu_pend;
    if (rf_we === 1'b1) rf_obs[rf_waddr] = rf_wdata;
    exp_stall = e_stall;
    @(posedge clk);
    if (r) begin
      pend_q.delete();
      starve = 0;
    end else begin
      if (lu_win) begin
        void'(pend_q.pop_front());
        starve = 0;
      end else if (counted && pend_q.size() > 0) begin
        starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      end
      if (e_ready && lv && ld != 5'd0) begin
        pend_q.push_back('{ld, ldat});
        starve = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  logic        h_v;
  logic [4:0]  h_d;
  logic [31:0] h_dat;

  initial begin
    n_vec = 0; n_err = 0; starve = 0; exp_stall = 1'b0;
    for (int i = 0; i < 32; i++) rf_obs[i] = '0;
    reset = 1'b1; ws_wr_valid = 1'b0; ws_wr_dest = '0; ws_wr_data = '0;
    lu_valid = 1'b0; lu_dest = '0; lu_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then LU write with WB idle lands one cycle later.
    idle();
    check("rst_ready", 64'(obs_ready), 64'(1));
    check("rst_we",    64'(obs_we),    64'(0));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
    check("lu_acc_ready", 64'(obs_ready), 64'(1));
    check("lu_acc_nowe",  64'(obs_we),    64'(0));
    idle();
    check("lu_wr_addr", 64'(obs_addr), 64'(5));
    check("lu_wr_data", 64'(obs_data), 64'(32'h11));
    idle();
    check("lu_drained", 64'(obs_pend), 64'(0));

    // Starvation: WB wins LIMIT times, then LU is forced.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
      check("starve_addr",  64'(obs_addr),  64'((i == 3) ? 7 : 3));
      check("starve_stall", 64'(obs_stall), 64'(i == 3));
    end

    // WAW: same destination, LU (older) commits first.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hA);
    step(1'b0, 1'b1, 5'd9, 32'hB, 1'b0, 5'd0, 32'd0);
    check("waw_first",  64'(obs_data),  64'(32'hA));
    check("waw_stall",  64'(obs_stall), 64'(1));
    step(1'b0, 1'b1, 5'd9, 32'hB, 1'b0, 5'd0, 32'd0);
    check("waw_second", 64'(obs_data),  64'(32'hB));
    check("waw_r9",     64'(rf_obs[9]), 64'(32'hB));

    // r0 destinations.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    check("lu0_ready", 64'(obs_ready), 64'(1));
    idle();
    check("lu0_pend", 64'(obs_pend), 64'(0));
    check("lu0_we",   64'(obs_we),   64'(0));
    step(1'b0, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0);
    check("wb0_we",    64'(obs_we),    64'(0));
    check("wb0_stall", 64'(obs_stall), 64'(0));

    // Reset discards a buffered write.
    rf_obs[4] = 32'hDEAD_BEEF;
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("rstbuf_ready", 64'(obs_ready), 64'(1));
      check("rstbuf_pend",  64'(obs_pend),  64'(0));
    end
    check("rstbuf_r4", 64'(rf_obs[4]), 64'(32'hDEAD_BEEF));

    // Back-to-back LU offers: accept on alternate cycles only.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'(i + 100));
      check("b2b_ready", 64'(obs_ready), 64'(i % 2 == 0));
      check("b2b_we",    64'(obs_we),    64'(i % 2 == 1));
    end
    idle();

    // Randomized traffic; a stalled WB request is re-presented unchanged.
    h_v = 1'b0; h_d = '0; h_dat = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!exp_stall) begin
        h_v   = ($urandom_range(0, 3) != 0);
        h_d   = 5'($urandom_range(0, 7));
        h_dat = $urandom;
      end
      step(($urandom_range(0, 63) == 0), h_v, h_d, h_dat,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
